// File: rtl/reg_file_wr_arb.sv
// reg_file_wr_arb: round-robin arbiter for the MIPS register-file write
// port (addr3/wd3/we3). It shares the port between NUM_REQ writeback
// requesters using a valid/ready handshake, and all write-port outputs
// are registered.
// Optional build macro RF_ARB_CLEAR_EN: after reset, the block writes
// zero to registers 1..2**ADDR_W-1 before it accepts any request.
module reg_file_wr_arb #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  output logic [ADDR_W-1:0]           addr3_o,
  output logic [DATA_W-1:0]           wd3_o,
  output logic                        we3_en_o,
  output logic                        busy_o
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wd_q, wd_d;
  logic               we_q, we_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] grant;
  logic               found;
  int unsigned        gidx;
  logic               run_en;

`ifdef RF_ARB_CLEAR_EN
  typedef enum logic {S_RUN, S_CLEAR} state_t;
  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;

  assign run_en = (state_q == S_RUN);
  assign busy_o = (state_q == S_CLEAR);
`else
  assign run_en = 1'b1;
  assign busy_o = 1'b0;
`endif

  // Round-robin search: first valid requester at or after the pointer
  always_comb begin
    grant = '0;
    gidx  = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid_i[(32'(ptr_q) + i) % NUM_REQ]) begin
        found = 1'b1;
        gidx  = (32'(ptr_q) + i) % NUM_REQ;
      end
    end
    if (found) grant[gidx] = 1'b1;
  end

  assign req_ready_o = run_en ? grant : '0;

  // Next-state for the write port, pointer and (optionally) clear sequencer
  always_comb begin
    addr_d = addr_q;
    wd_d   = wd_q;
    we_d   = 1'b0;
    ptr_d  = ptr_q;
`ifdef RF_ARB_CLEAR_EN
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_CLEAR) begin
      addr_d = cnt_q;
      wd_d   = '0;
      we_d   = 1'b1;
      cnt_d  = cnt_q + ADDR_W'(1);
      if (cnt_q == '1) state_d = S_RUN;
    end else
`endif
    if (found) begin
      addr_d = req_addr_i[gidx*ADDR_W +: ADDR_W];
      wd_d   = req_data_i[gidx*DATA_W +: DATA_W];
      // $zero is never written, but the transfer is still consumed
      we_d   = |req_addr_i[gidx*ADDR_W +: ADDR_W];
      ptr_d  = PTR_W'((gidx + 1) % NUM_REQ);
    end
  end

  // Registered write port and round-robin pointer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q <= '0;
      wd_q   <= '0;
      we_q   <= 1'b0;
      ptr_q  <= '0;
    end else begin
      addr_q <= addr_d;
      wd_q   <= wd_d;
      we_q   <= we_d;
      ptr_q  <= ptr_d;
    end
  end

`ifdef RF_ARB_CLEAR_EN
  // Clear sequencer state and address counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_CLEAR;
      cnt_q   <= ADDR_W'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`endif

  assign addr3_o  = addr_q;
  assign wd3_o    = wd_q;
  assign we3_en_o = we_q;

endmodule

// File: doc/reg_file_wr_arb.md
Name: reg_file_wr_arb

Overview:
- Arbiter and sequencer for the single write port (addr3/wd3/we3) of the MIPS register file.
- Shares the port between NUM_REQ writeback requesters (e.g. ALU result, load data) with round-robin priority and a valid/ready handshake.
- Drives registered write-port signals. After reset it can optionally run a clear sequence that zeroes every register.

Parameters:
- NUM_REQ, 2, number of write requesters (2..4)
- ADDR_W, 5, register address width
- DATA_W, 32, register data width

Ports:
- clk_i  in  1  clock, all state updates on posedge
- rst_i  in  1  asynchronous active-high reset
- req_valid_i  in  NUM_REQ  per-requester write request
- req_addr_i  in  NUM_REQ*ADDR_W  packed destination addresses; requester k at bits [k*ADDR_W +: ADDR_W]
- req_data_i  in  NUM_REQ*DATA_W  packed write data; requester k at bits [k*DATA_W +: DATA_W]
- req_ready_o  out  NUM_REQ  one-hot grant; combinational from state, pointer and req_valid_i
- addr3_o  out  ADDR_W  register file write address
- wd3_o  out  DATA_W  register file write data
- we3_en_o  out  1  register file write enable
- busy_o  out  1  high while the clear sequence runs

Behaviour:
- Reset values:
  - we3_en_o=0, addr3_o=0, wd3_o=0.
  - Round-robin pointer=0 (requester 0 has highest priority).
  - Clear counter=1.
  - State=CLEAR with RF_ARB_CLEAR_EN defined, RUN without it.
  - busy_o=1 in CLEAR, 0 in RUN.
- Reset asserted mid-operation aborts any clear or pending write immediately. we3_en_o drops asynchronously and no partial write is issued.
- State CLEAR:
  - req_ready_o=0.
  - Each cycle registers addr3_o=counter, wd3_o=0, we3_en_o=1, then increments counter.
  - Covers addresses 1..31: 31 consecutive write cycles.
  - After the cycle writing address 31 -> RUN. busy_o falls in the same cycle as the transition.
- State RUN, arbitration:
  - Grant goes to the lowest-index valid requester at or after the pointer, wrapping modulo NUM_REQ.
  - req_ready_o is one-hot for that requester and 0 when no request is valid.
  - A transfer occurs when req_valid_i[k] && req_ready_o[k] at posedge.
- State RUN, on a transfer:
  - Next cycle addr3_o=req_addr_i[k], wd3_o=req_data_i[k].
  - we3_en_o=1, except when the address is 0 ($zero): the transfer is still accepted but we3_en_o stays 0.
  - Pointer moves to (k+1) mod NUM_REQ.
- With no transfer: we3_en_o=0, addr3_o/wd3_o hold their previous values, pointer unchanged.
- Latency: exactly 1 cycle from accept edge to we3_en_o high. Throughput 1 write per cycle.
- Losing requesters hold valid/addr/data stable until accepted; the block does not buffer them.
- Two requesters targeting the same address in consecutive grants: both writes are issued in grant order, so the last granted wins.
- req_valid_i is ignored in CLEAR; requests held across the CLEAR->RUN transition are granted in the first RUN cycle.

Optional Feature:
- Macro RF_ARB_CLEAR_EN.
- Defined: CLEAR state exists as described; busy_o=1 for 31 cycles after reset release.
- Undefined: no CLEAR state or counter logic; the block enters RUN at reset and busy_o is tied to 0.

Test Plan:
- Clear sequence (RF_ARB_CLEAR_EN defined): release reset with requests held -> we3_en_o=1 for 31 consecutive cycles, addr3_o 1..31, wd3_o=0, req_ready_o=0 throughout; busy_o falls after address 31; first grant goes to requester 0.
- Single request: req0 valid, addr=5'b00001, data=32'h00001010 -> req_ready_o=2'b01. Next cycle we3_en_o=1, addr3_o=1, wd3_o=32'h00001010.
- Round robin, both valid continuously: req0 addr=2, req1 addr=3 -> grants alternate 01,10,01,10; we3 writes alternate addr 2,3 with one write per cycle.
- $zero write: req1 addr=0, data=32'hFFFFFFFF -> req_ready_o[1]=1, next cycle we3_en_o=0; pointer advances to 0.
- Reset mid-CLEAR: assert rst_i while addr3_o=10 -> we3_en_o=0 immediately; after release the clear restarts at address 1.
- Macro undefined: after reset busy_o=0; req1 valid addr=5'b10100 in the first cycle -> granted, with we3_en_o=1 and addr3_o=20 one cycle later.
